// File: rtl/load_buffer_pkg.sv
// Shared definitions for the load buffer: memory access sizes, entry states
// and default geometry.
package load_buffer_pkg;

  localparam int LB_DEPTH_DEF = 4;
  localparam int TAG_W_DEF    = 5;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  // Lifecycle of one buffer entry.
  typedef enum logic [1:0] {
    LB_FREE = 2'd0,
    LB_WAIT = 2'd1,
    LB_PEND = 2'd2,
    LB_DONE = 2'd3
  } lb_state_e;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a memory word and sign- or
// zero-extends it to 32 bits. Misaligned offsets are aligned down.
module load_align
  import load_buffer_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    // Only offset[1] matters for halves; offset[0] is dropped (aligned down).
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    value = word;
    case (size)
      MEM_BYTE: value = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      MEM_HALF: value = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default:  value = word;
    endcase
  end

endmodule

// File: rtl/load_buffer.sv
// In-order load buffer: circular FIFO of loads with one outstanding memory
// read, in-order writeback and a squash path for reads in flight at a flush.
module load_buffer
  import load_buffer_pkg::*;
#(
  parameter int LB_DEPTH = LB_DEPTH_DEF,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              acu_rd_mem,
  input  logic [31:0]       acu_addr,
  input  logic [1:0]        acu_size,
  input  logic              acu_unsigned,
  input  logic [TAG_W-1:0]  acu_tag,
  output logic              lb_full,
  input  logic              lb_exec_stall,
  output logic              lb_read_mem,
  output logic [31:0]       lb2mem_addr,
  input  logic              mem2lb_valid,
  input  logic [31:0]       mem2lb_data,
  output logic              lb_wr_valid,
  output logic [31:0]       lb_wr_value,
  output logic [TAG_W-1:0]  lb_wr_tag,
  input  logic              lb_wr_written,
  input  logic              branch_misprediction
);

  // Handshakes: an allocation happens when acu_rd_mem=1 and lb_full=0 at the
  // edge; a read issues when lb_read_mem=1 at the edge (memory has no ready);
  // a result retires when lb_wr_valid=1 and lb_wr_written=1 at the edge, and
  // value/tag are held stable until then.

  localparam int PTR_W = $clog2(LB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lb_state_e        st_q [LB_DEPTH];
  lb_state_e        st_d [LB_DEPTH];
  logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PTR_W-1:0] iss_ptr_q, iss_ptr_d;
  logic [PTR_W-1:0] wb_ptr_q, wb_ptr_d;
  logic [PTR_W-1:0] out_idx_q, out_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             squash_q, squash_d;

  logic [31:0]      addr_q [LB_DEPTH];
  logic [1:0]       size_q [LB_DEPTH];
  logic             uns_q  [LB_DEPTH];
  logic [TAG_W-1:0] tag_q  [LB_DEPTH];
  logic [31:0]      data_q [LB_DEPTH];

  logic        full;
  logic        alloc_fire;
  logic        issue_fire;
  logic        resp_fire;
  logic        wb_valid;
  logic        wb_fire;
  logic [31:0] aligned_value;

  always_comb begin
    full       = (cnt_q == CNT_W'(LB_DEPTH));
    alloc_fire = acu_rd_mem && !full;
    issue_fire = (st_q[iss_ptr_q] == LB_WAIT) && !out_q && !squash_q &&
                 !lb_exec_stall && !branch_misprediction;
    resp_fire  = mem2lb_valid && out_q;
    wb_valid   = (st_q[wb_ptr_q] == LB_DONE);
    wb_fire    = wb_valid && lb_wr_written;
  end

  load_align u_align (
    .word        (mem2lb_data),
    .offset      (addr_q[out_idx_q][1:0]),
    .size        (size_q[out_idx_q]),
    .is_unsigned (uns_q[out_idx_q]),
    .value       (aligned_value)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < LB_DEPTH; i++) st_q[i] <= LB_FREE;
      alloc_ptr_q <= '0;
      iss_ptr_q   <= '0;
      wb_ptr_q    <= '0;
      out_idx_q   <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      squash_q    <= 1'b0;
    end else begin
      for (int i = 0; i < LB_DEPTH; i++) st_q[i] <= st_d[i];
      alloc_ptr_q <= alloc_ptr_d;
      iss_ptr_q   <= iss_ptr_d;
      wb_ptr_q    <= wb_ptr_d;
      out_idx_q   <= out_idx_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      squash_q    <= squash_d;
    end
  end

  // Next-state logic. Alloc, issue, response and writeback always touch
  // distinct entries (FREE, WAIT, PEND, DONE respectively), so they compose.
  always_comb begin
    for (int i = 0; i < LB_DEPTH; i++) st_d[i] = st_q[i];
    alloc_ptr_d = alloc_ptr_q;
    iss_ptr_d   = iss_ptr_q;
    wb_ptr_d    = wb_ptr_q;
    out_idx_d   = out_idx_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    squash_d    = squash_q;

    if (alloc_fire) begin
      st_d[alloc_ptr_q] = LB_WAIT;
      alloc_ptr_d       = alloc_ptr_q + 1'b1;
    end
    if (issue_fire) begin
      st_d[iss_ptr_q] = LB_PEND;
      iss_ptr_d       = iss_ptr_q + 1'b1;
      out_idx_d       = iss_ptr_q;
      out_d           = 1'b1;
    end
    if (resp_fire) begin
      st_d[out_idx_q] = LB_DONE;
      out_d           = 1'b0;
    end
    if (mem2lb_valid && squash_q) squash_d = 1'b0;
    if (wb_fire) begin
      st_d[wb_ptr_q] = LB_FREE;
      wb_ptr_d       = wb_ptr_q + 1'b1;
    end

    case ({alloc_fire, wb_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // A response arriving in the flush cycle itself retires the read, so
    // only a read still in flight after this edge needs squashing.
    if (branch_misprediction) begin
      for (int i = 0; i < LB_DEPTH; i++) st_d[i] = LB_FREE;
      alloc_ptr_d = '0;
      iss_ptr_d   = '0;
      wb_ptr_d    = '0;
      out_idx_d   = '0;
      cnt_d       = '0;
      out_d       = 1'b0;
      squash_d    = (out_q || squash_q) && !mem2lb_valid;
    end
  end

  // Entry payload; written only where the control path accepts the event.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < LB_DEPTH; i++) begin
        addr_q[i] <= '0;
        size_q[i] <= '0;
        uns_q[i]  <= 1'b0;
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (!branch_misprediction) begin
      if (alloc_fire) begin
        addr_q[alloc_ptr_q] <= acu_addr;
        size_q[alloc_ptr_q] <= acu_size;
        uns_q[alloc_ptr_q]  <= acu_unsigned;
        tag_q[alloc_ptr_q]  <= acu_tag;
        data_q[alloc_ptr_q] <= '0;
      end
      if (resp_fire) data_q[out_idx_q] <= aligned_value;
    end
  end

  // Outputs; all forced quiet while reset is asserted.
  always_comb begin
    lb_full     = reset_n && full;
    lb_read_mem = reset_n && issue_fire;
    lb2mem_addr = lb_read_mem ? {addr_q[iss_ptr_q][31:2], 2'b00} : 32'd0;
    lb_wr_valid = reset_n && wb_valid;
    lb_wr_value = lb_wr_valid ? data_q[wb_ptr_q] : 32'd0;
    lb_wr_tag   = lb_wr_valid ? tag_q[wb_ptr_q] : '0;
  end

endmodule

// File: tb/tb_load_buffer.sv
// Bench for load_buffer: directed scenarios followed by a randomized phase
// checked against a queue-based model of in-order load completion.
module tb_load_buffer;
  import load_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int TW    = 5;

  logic          clock;
  logic          reset_n;
  logic          acu_rd_mem;
  logic [31:0]   acu_addr;
  logic [1:0]    acu_size;
  logic          acu_unsigned;
  logic [TW-1:0] acu_tag;
  logic          lb_full;
  logic          lb_exec_stall;
  logic          lb_read_mem;
  logic [31:0]   lb2mem_addr;
  logic          mem2lb_valid;
  logic [31:0]   mem2lb_data;
  logic          lb_wr_valid;
  logic [31:0]   lb_wr_value;
  logic [TW-1:0] lb_wr_tag;
  logic          lb_wr_written;
  logic          branch_misprediction;

  int tests = 0;
  int fails = 0;

  load_buffer #(.LB_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .acu_rd_mem           (acu_rd_mem),
    .acu_addr             (acu_addr),
    .acu_size             (acu_size),
    .acu_unsigned         (acu_unsigned),
    .acu_tag              (acu_tag),
    .lb_full              (lb_full),
    .lb_exec_stall        (lb_exec_stall),
    .lb_read_mem          (lb_read_mem),
    .lb2mem_addr          (lb2mem_addr),
    .mem2lb_valid         (mem2lb_valid),
    .mem2lb_data          (mem2lb_data),
    .lb_wr_valid          (lb_wr_valid),
    .lb_wr_value          (lb_wr_value),
    .lb_wr_tag            (lb_wr_tag),
    .lb_wr_written        (lb_wr_written),
    .branch_misprediction (branch_misprediction)
  );

  // Clock / watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    acu_rd_mem           = 1'b0;
    acu_addr             = '0;
    acu_size             = '0;
    acu_unsigned         = 1'b0;
    acu_tag              = '0;
    lb_exec_stall        = 1'b0;
    mem2lb_valid         = 1'b0;
    mem2lb_data          = '0;
    lb_wr_written        = 1'b0;
    branch_misprediction = 1'b0;
  endtask

  task automatic alloc(input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [TW-1:0] tag);
    acu_rd_mem   = 1'b1;
    acu_addr     = addr;
    acu_size     = size;
    acu_unsigned = uns;
    acu_tag      = tag;
    step();
    acu_rd_mem   = 1'b0;
  endtask

  task automatic serve_read(input string name, input logic [31:0] exp_addr,
                            input logic [31:0] data);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      settle();
      if (lb_read_mem) found = 1;
      else step();
    end
    chk({name, "_issue"}, 32'(found), 32'd1);
    chk({name, "_addr"}, lb2mem_addr, exp_addr);
    step();
    mem2lb_valid = 1'b1;
    mem2lb_data  = data;
    step();
    mem2lb_valid = 1'b0;
  endtask

  task automatic expect_wb(input string name, input logic [TW-1:0] tag,
                           input logic [31:0] value);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      settle();
      if (lb_wr_valid) found = 1;
      else step();
    end
    chk({name, "_valid"}, 32'(found), 32'd1);
    chk({name, "_tag"}, 32'(lb_wr_tag), 32'(tag));
    chk({name, "_value"}, lb_wr_value, value);
    lb_wr_written = 1'b1;
    step();
    lb_wr_written = 1'b0;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_full"}, 32'(lb_full), 32'd0);
    chk({name, "_read"}, 32'(lb_read_mem), 32'd0);
    chk({name, "_addr"}, lb2mem_addr, 32'd0);
    chk({name, "_wvalid"}, 32'(lb_wr_valid), 32'd0);
    chk({name, "_wvalue"}, lb_wr_value, 32'd0);
    chk({name, "_wtag"}, 32'(lb_wr_tag), 32'd0);
  endtask

  // Scoreboard / reference model
  typedef struct {
    logic [31:0]   addr;
    logic [1:0]    size;
    logic          uns;
    logic [TW-1:0] tag;
  } desc_t;

  desc_t         iq[$];        // accepted loads whose read has not issued
  logic [31:0]   exp_q[$];     // completed results in allocation order
  logic [TW-1:0] exp_tag_q[$];
  int            occ = 0;
  bit            m_out = 0;
  int            m_wait = 0;
  desc_t         m_desc;

  function automatic logic [31:0] model_value(desc_t d, logic [31:0] w);
    int unsigned off = 32'(d.addr[1:0]);
    logic [31:0] v;
    if (d.size == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!d.uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (d.size == 2'd1) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (!d.uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic rnd_cycle(input bit busy);
    bit    rsp_now = 0;
    bit    exp_rd;
    bit    was_full;
    desc_t d;
    acu_rd_mem    = busy && ($urandom_range(0, 1) == 1);
    acu_addr      = $urandom;
    acu_size      = 2'($urandom_range(0, 2));
    acu_unsigned  = 1'($urandom_range(0, 1));
    acu_tag       = TW'($urandom_range(0, 31));
    lb_exec_stall = busy && ($urandom_range(0, 4) == 0);
    lb_wr_written = busy ? 1'($urandom_range(0, 1)) : 1'b1;
    if (m_out) begin
      if (m_wait == 0) rsp_now = 1;
      else m_wait--;
    end
    mem2lb_valid = rsp_now || (!m_out && ($urandom_range(0, 9) == 0));
    mem2lb_data  = $urandom;
    settle();

    was_full = (occ == DEPTH);
    chk("rnd_full", 32'(lb_full), 32'(was_full));
    exp_rd = !m_out && (iq.size() != 0) && !lb_exec_stall;
    chk("rnd_read", 32'(lb_read_mem), 32'(exp_rd));
    chk("rnd_wvalid", 32'(lb_wr_valid), 32'(exp_q.size() != 0));
    if (lb_wr_valid && exp_q.size() != 0) begin
      chk("rnd_wvalue", lb_wr_value, exp_q[0]);
      chk("rnd_wtag", 32'(lb_wr_tag), 32'(exp_tag_q[0]));
      if (lb_wr_written) begin
        void'(exp_q.pop_front());
        void'(exp_tag_q.pop_front());
        occ--;
      end
    end
    if (rsp_now) begin
      exp_q.push_back(model_value(m_desc, mem2lb_data));
      exp_tag_q.push_back(m_desc.tag);
      m_out = 0;
    end
    if (lb_read_mem && exp_rd) begin
      chk("rnd_raddr", lb2mem_addr, {iq[0].addr[31:2], 2'b00});
      m_desc = iq.pop_front();
      m_out  = 1;
      m_wait = $urandom_range(0, 3);
    end
    if (acu_rd_mem && !was_full) begin
      d.addr = acu_addr;
      d.size = acu_size;
      d.uns  = acu_unsigned;
      d.tag  = acu_tag;
      iq.push_back(d);
      occ++;
    end
    step();
  endtask

  // Directed sequence, then randomized phase, then report
  initial begin
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_quiet("reset");
    reset_n = 1'b1;
    settle();
    chk_quiet("post_reset");
    step();

    // Single aligned word load with two-cycle memory latency.
    acu_rd_mem = 1'b1; acu_addr = 32'h100; acu_size = MEM_WORD; acu_tag = 5'd3;
    settle();
    chk("basic_no_early_read", 32'(lb_read_mem), 32'd0);
    step();
    acu_rd_mem = 1'b0;
    settle();
    chk("basic_read", 32'(lb_read_mem), 32'd1);
    chk("basic_addr", lb2mem_addr, 32'h100);
    step();
    settle();
    chk("basic_one_outstanding", 32'(lb_read_mem), 32'd0);
    step();
    mem2lb_valid = 1'b1; mem2lb_data = 32'hDEAD_BEEF;
    settle();
    chk("basic_wvalid_same_cycle", 32'(lb_wr_valid), 32'd0);
    step();
    mem2lb_valid = 1'b0;
    settle();
    chk("basic_wvalid", 32'(lb_wr_valid), 32'd1);
    chk("basic_wvalue", lb_wr_value, 32'hDEAD_BEEF);
    chk("basic_wtag", 32'(lb_wr_tag), 32'd3);
    lb_wr_written = 1'b1;
    step();
    lb_wr_written = 1'b0;
    settle();
    chk("basic_retired", 32'(lb_wr_valid), 32'd0);
    step();

    // Fill the buffer; allocations while full are dropped, even alongside a writeback.
    lb_exec_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      acu_rd_mem = 1'b1; acu_addr = 32'h200 + 32'(4 * k); acu_size = MEM_WORD;
      acu_tag = TW'(10 + k);
      settle();
      chk("fill_not_full", 32'(lb_full), 32'd0);
      step();
    end
    acu_addr = 32'h300; acu_tag = 5'd9;
    settle();
    chk("fill_full", 32'(lb_full), 32'd1);
    step();
    acu_rd_mem = 1'b0;
    settle();
    chk("fill_still_full", 32'(lb_full), 32'd1);
    lb_exec_stall = 1'b0;
    serve_read("fill0", 32'h200, 32'h1111_1111);
    lb_exec_stall = 1'b1;
    settle();
    chk("fill0_wvalid", 32'(lb_wr_valid), 32'd1);
    chk("fill0_wtag", 32'(lb_wr_tag), 32'd10);
    chk("fill0_full_before_wb", 32'(lb_full), 32'd1);
    acu_rd_mem = 1'b1; acu_addr = 32'h300; acu_tag = 5'd9;
    lb_wr_written = 1'b1;
    step();
    acu_rd_mem = 1'b0; lb_wr_written = 1'b0; lb_exec_stall = 1'b0;
    settle();
    chk("fill_full_cleared", 32'(lb_full), 32'd0);
    serve_read("fill1", 32'h204, 32'h2222_2222);
    serve_read("fill2", 32'h208, 32'h3333_3333);
    serve_read("fill3", 32'h20C, 32'h4444_4444);
    expect_wb("fill1_wb", 5'd11, 32'h2222_2222);
    expect_wb("fill2_wb", 5'd12, 32'h3333_3333);
    expect_wb("fill3_wb", 5'd13, 32'h4444_4444);
    settle();
    chk("fill_no_phantom_read", 32'(lb_read_mem), 32'd0);
    chk("fill_no_phantom_wb", 32'(lb_wr_valid), 32'd0);
    step();

    // Sub-word extraction, extension and misaligned accesses.
    alloc(32'h103, MEM_BYTE, 1'b0, 5'd1);
    serve_read("bs", 32'h100, 32'h80FF_0000);
    expect_wb("bs_wb", 5'd1, 32'hFFFF_FF80);
    alloc(32'h103, MEM_BYTE, 1'b1, 5'd2);
    serve_read("bu", 32'h100, 32'h80FF_0000);
    expect_wb("bu_wb", 5'd2, 32'h0000_0080);
    alloc(32'h102, MEM_HALF, 1'b0, 5'd4);
    serve_read("hs", 32'h100, 32'h80FF_0000);
    expect_wb("hs_wb", 5'd4, 32'hFFFF_80FF);
    alloc(32'h103, MEM_HALF, 1'b1, 5'd5);
    serve_read("hmis", 32'h100, 32'h80FF_0000);
    expect_wb("hmis_wb", 5'd5, 32'h0000_80FF);
    alloc(32'h101, MEM_WORD, 1'b0, 5'd6);
    serve_read("wmis", 32'h100, 32'hCAFE_F00D);
    expect_wb("wmis_wb", 5'd6, 32'hCAFE_F00D);

    // Execution stall holds back the read until it drops.
    lb_exec_stall = 1'b1;
    alloc(32'h700, MEM_WORD, 1'b0, 5'd8);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_read_low", 32'(lb_read_mem), 32'd0);
      step();
    end
    lb_exec_stall = 1'b0;
    settle();
    chk("stall_release_read", 32'(lb_read_mem), 32'd1);
    chk("stall_release_addr", lb2mem_addr, 32'h700);
    step();
    mem2lb_valid = 1'b1; mem2lb_data = 32'h5A5A_5A5A;
    step();
    mem2lb_valid = 1'b0;
    expect_wb("stall_wb", 5'd8, 32'h5A5A_5A5A);

    // Flush with a read in flight; the stale response must be dropped.
    alloc(32'h400, MEM_WORD, 1'b0, 5'd6);
    settle();
    chk("flush_pre_read", 32'(lb_read_mem), 32'd1);
    step();
    branch_misprediction = 1'b1;
    settle();
    chk("flush_cycle_read", 32'(lb_read_mem), 32'd0);
    step();
    branch_misprediction = 1'b0;
    alloc(32'h500, MEM_WORD, 1'b0, 5'd7);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("squash_hold_read", 32'(lb_read_mem), 32'd0);
      step();
    end
    mem2lb_valid = 1'b1; mem2lb_data = 32'hBAD0_BAD0;
    settle();
    chk("squash_rsp_read", 32'(lb_read_mem), 32'd0);
    step();
    mem2lb_valid = 1'b0;
    settle();
    chk("stale_dropped", 32'(lb_wr_valid), 32'd0);
    serve_read("post_flush", 32'h500, 32'h1234_5678);
    expect_wb("post_flush_wb", 5'd7, 32'h1234_5678);

    // Spurious response with nothing outstanding.
    mem2lb_valid = 1'b1; mem2lb_data = 32'hFFFF_FFFF;
    step();
    mem2lb_valid = 1'b0;
    settle();
    chk("spurious_ignored", 32'(lb_wr_valid), 32'd0);

    // Result held under writeback backpressure, then reset mid-hold.
    alloc(32'h602, MEM_HALF, 1'b1, 5'd21);
    serve_read("hold", 32'h600, 32'hABCD_1234);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("hold_valid", 32'(lb_wr_valid), 32'd1);
      chk("hold_value", lb_wr_value, 32'h0000_ABCD);
      chk("hold_tag", 32'(lb_wr_tag), 32'd21);
      step();
    end
    reset_n = 1'b0;
    step();
    chk_quiet("mid_reset");
    reset_n = 1'b1;
    settle();
    chk_quiet("mid_reset_release");
    step();

    // Randomized traffic against the model, then drain.
    for (int i = 0; i < 600; i++) rnd_cycle(1'b1);
    for (int i = 0; i < 80; i++) rnd_cycle(1'b0);
    chk("drain_occ", 32'(occ), 32'd0);
    chk("drain_pending", 32'(iq.size() + exp_q.size()), 32'd0);
    settle();
    chk("drain_full", 32'(lb_full), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_buffer.md
LOAD_BUFFER -- requirements
Module: load_buffer

Interface
REQ-001 SHALL have parameters: LB_DEPTH, default 4, number of entries (power of 2); TAG_W, default 5, ROB tag width.
REQ-002 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 acu_rd_mem  in  1  allocate a load this cycle; acu_addr  in  32  byte address; acu_size  in  2  BYTE/HALF/WORD; acu_unsigned  in  1  zero-extend; acu_tag  in  TAG_W  ROB tag.
REQ-005 lb_full  out  1  no free entry.
REQ-006 lb_exec_stall  in  1  suppress new memory reads (store commit or writeback backpressure).
REQ-007 lb_read_mem  out  1  memory read request; lb2mem_addr  out  32  word-aligned address; mem2lb_valid  in  1  read data valid; mem2lb_data  in  32  read word.
REQ-008 lb_wr_valid  out  1  result available; lb_wr_value  out  32  extended load value; lb_wr_tag  out  TAG_W  ROB tag; lb_wr_written  in  1  result consumed by the CDB this cycle.
REQ-009 branch_misprediction  in  1  flush all entries.

Function
REQ-010 SHALL hold entries in a circular FIFO with alloc, issue and writeback pointers, each of width log2(LB_DEPTH), wrapping from LB_DEPTH-1 to 0.
REQ-011 Entry states SHALL be FREE -> WAIT (allocated) -> PEND (read issued) -> DONE (data latched) -> FREE (written back).
REQ-012 lb_full SHALL be 1 when the registered occupancy count equals LB_DEPTH; acu_rd_mem while lb_full SHALL be ignored, even if a writeback frees an entry the same cycle.
REQ-013 Allocation SHALL write addr/size/unsigned/tag into the alloc-pointer entry, set WAIT, and advance the pointer at the rising edge.
REQ-014 lb_read_mem SHALL be combinationally 1 iff the issue-pointer entry is WAIT, no read is outstanding, no squashed read is outstanding, lb_exec_stall=0 and branch_misprediction=0; lb2mem_addr = {addr[31:2],2'b00}.
REQ-015 At most one read SHALL be outstanding; on issue the entry goes PEND and the issue pointer advances.
REQ-016 mem2lb_valid SHALL complete the outstanding read with arbitrary latency >= 1 cycle; data is extracted using addr[1:0] and size, sign- or zero-extended to 32 bits, stored, and the entry goes DONE.
REQ-017 Misaligned HALF (addr[0]=1) or WORD (addr[1:0]!=0) SHALL be treated as aligned down; no exception is raised.
REQ-018 lb_wr_valid SHALL be 1 iff the writeback-pointer entry is DONE, i.e. no earlier than the cycle after mem2lb_valid; results leave in allocation order.
REQ-019 lb_wr_value/lb_wr_tag SHALL remain stable while lb_wr_valid=1 and lb_wr_written=0; lb_wr_written=1 frees the entry and advances the pointer.
REQ-020 lb_wr_written while lb_wr_valid=0 SHALL be ignored.
REQ-021 Allocate and writeback in the same cycle SHALL leave occupancy unchanged.
REQ-022 branch_misprediction SHALL, at the edge, set all entries FREE, zero all pointers and the count, and take priority over same-cycle allocate, issue, response and writeback.
REQ-023 If a read is outstanding at flush, a squash flag SHALL be set; the next mem2lb_valid clears it and is discarded; lb_read_mem stays 0 while it is set.
REQ-024 mem2lb_valid with nothing outstanding SHALL be ignored.

Reset
REQ-025 reset_n=0 at a rising edge SHALL clear all entries to FREE and clear pointers, count, outstanding and squash flags, including mid-transaction.
REQ-026 While and after reset: lb_full=0, lb_read_mem=0, lb_wr_valid=0; lb_wr_value, lb_wr_tag and lb2mem_addr = 0.

Structure
REQ-027 Memory-size encoding (BYTE=0, HALF=1, WORD=2), LB_DEPTH and TAG_W defaults SHALL live in the shared system-definitions package.
REQ-028 Byte/half extraction and extension SHALL be a combinational sub-module load_align (inputs word, offset, size, unsigned; output 32-bit value).

Verification
REQ-029 Alloc LB addr 0x100 WORD tag 3; mem returns 0xDEADBEEF after 2 cycles -> lb_read_mem one cycle after alloc, lb_wr_valid next cycle after response with value 0xDEADBEEF, tag 3.
REQ-030 Alloc 4 loads, no writeback -> lb_full=1; 5th acu_rd_mem ignored; one lb_wr_written -> lb_full=0 next cycle.
REQ-031 BYTE signed at 0x103, mem word 0x80FF0000 -> value 0xFFFFFF80; same as unsigned -> 0x00000080; HALF signed at 0x102 -> 0xFFFF80FF.
REQ-032 Hold lb_exec_stall=1 for 3 cycles with WAIT entry -> lb_read_mem=0 throughout, asserted the cycle stall drops.
REQ-033 Flush with read outstanding, then alloc tag 7 -> no read until stale response arrives and is dropped; tag 7 then issued and written back with new data.
REQ-034 Hold lb_wr_written=0 for 5 cycles with DONE entry -> value/tag stable; reset_n=0 mid-stall -> all outputs 0 next cycle.
